// File: rtl/fractal_sync_pkg.sv
// Shared types for the fractal sync endpoint blocks: initiator FSM states and tree-wide limits.
package fractal_sync_pkg;

    localparam int unsigned MAX_LVL_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } initiator_state_e;

endpackage

// File: rtl/fractal_sync_watchdog.sv
// Cycle watchdog for the initiator WAIT state: cleared on entry, counts while enabled,
// flags expiry in the cycle the count would reach LIMIT.
module fractal_sync_watchdog #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CntW = $clog2(LIMIT + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != CntW'(LIMIT))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The LIMIT-th enabled cycle is the last one spent waiting.
    assign expired_o = enable_i && (cnt_q == CntW'(LIMIT - 1));

endmodule

// File: rtl/fractal_sync_1d_initiator.sv
// Endpoint initiator of the fractal sync protocol: one barrier request to the 1D tree, then wait for its wake-up.
// Optional WAIT watchdog enabled by defining FRACTAL_SYNC_INITIATOR_TIMEOUT_EN.
module fractal_sync_1d_initiator
    import fractal_sync_pkg::*;
#(
    parameter int unsigned LEVEL_WIDTH    = 1,
    parameter int unsigned ID_WIDTH       = 1,
    parameter int unsigned MAX_LEVEL      = 1,
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [LEVEL_WIDTH-1:0] req_level_i,
    input  logic [ID_WIDTH-1:0]    req_id_i,
    output logic                   sync_valid_o,
    input  logic                   sync_ready_i,
    output logic [LEVEL_WIDTH-1:0] sync_level_o,
    output logic [ID_WIDTH-1:0]    sync_id_o,
    input  logic                   wake_valid_i,
    input  logic [LEVEL_WIDTH-1:0] wake_level_i,
    input  logic [ID_WIDTH-1:0]    wake_id_i,
    input  logic                   wake_err_i,
    output logic                   done_o,
    output logic                   err_o,
    output logic                   timeout_o,
    output logic                   stray_o,
    output logic                   busy_o,
    output logic [CNT_WIDTH-1:0]   sync_cnt_o
);

    initiator_state_e state_q, state_d;

    logic [LEVEL_WIDTH-1:0] level_q, level_d;
    logic [ID_WIDTH-1:0]    id_q, id_d;
    logic                   err_q, err_d;
    logic                   timeout_q, timeout_d;
    logic                   stray_q, stray_d;
    logic [CNT_WIDTH-1:0]   syncCnt_q, syncCnt_d;

    logic wakeMatch;
    logic levelIllegal;
    logic wdExpired;

    assign wakeMatch    = wake_valid_i && (wake_level_i == level_q) && (wake_id_i == id_q);
    assign levelIllegal = 32'(req_level_i) > MAX_LEVEL;

`ifdef FRACTAL_SYNC_INITIATOR_TIMEOUT_EN
    logic wdClear;
    logic wdEnable;

    assign wdClear  = (state_q == SEND) && sync_ready_i;
    assign wdEnable = (state_q == WAIT);

    fractal_sync_watchdog #(
        .LIMIT     (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (wdClear),
        .enable_i  (wdEnable),
        .expired_o (wdExpired)
    );
`else
    assign wdExpired = 1'b0;
`endif

    // err/timeout are only ever set on the transition into DONE, so they read 0 elsewhere.
    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        id_d      = id_q;
        err_d     = 1'b0;
        timeout_d = 1'b0;
        syncCnt_d = syncCnt_q;
        stray_d   = wake_valid_i && !((state_q == WAIT) && wakeMatch);

        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    level_d = req_level_i;
                    id_d    = req_id_i;
                    if (levelIllegal) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (sync_ready_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A matching wake on the watchdog expiry cycle takes priority.
                if (wakeMatch) begin
                    state_d = DONE;
                    err_d   = wake_err_i;
                    if (!wake_err_i) begin
                        syncCnt_d = syncCnt_q + 1'b1;
                    end
                end else if (wdExpired) begin
                    state_d   = DONE;
                    err_d     = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            level_q   <= '0;
            id_q      <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
            stray_q   <= 1'b0;
            syncCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            id_q      <= id_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
            stray_q   <= stray_d;
            syncCnt_q <= syncCnt_d;
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign busy_o       = (state_q != IDLE);
    assign sync_valid_o = (state_q == SEND);
    assign sync_level_o = level_q;
    assign sync_id_o    = id_q;
    assign done_o       = (state_q == DONE);
    assign err_o        = err_q;
    assign timeout_o    = timeout_q;
    assign stray_o      = stray_q;
    assign sync_cnt_o   = syncCnt_q;

endmodule
